// File: rtl/pattern_cfg_pkg.sv
// Shared constants and state encoding for the pattern-match register programming sequencer.
package pattern_cfg_pkg;

    localparam int CTRL_ADDR     = 0;
    localparam int PAT_BASE_ADDR = 1;
    localparam int ENABLE_BIT    = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIS_WR,
        S_PAT_WR,
        S_VER_RD,
        S_VER_WAIT,
        S_EN_WR,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/avalon_mm_if.sv
// Minimal Avalon-MM bundle with waitrequest and pipelined readdatavalid.
interface avalon_mm_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;
    logic              readdatavalid;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/amm_single_xfer.sv
// Executes one Avalon-MM read or write at a time; a new command may be loaded on the cycle
// the previous one acknowledges, so back-to-back transfers run without bubbles.
module amm_single_xfer #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              issue,
    input  logic              issue_wr,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_data,
    output logic              ack,
    output logic              rd_acc,
    output logic              timeout,
    output logic [DATA_W-1:0] rdata,
    avalon_mm_if.master       amm
);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    logic          rd_wait;
    logic [CW-1:0] wait_cnt;
    logic          wr_done;
    logic          tmo_hit;

    assign wr_done = amm.write & ~amm.waitrequest;
    assign rd_acc  = amm.read & ~amm.waitrequest;
    assign tmo_hit = (wait_cnt == CW'(RD_TIMEOUT - 1));
    assign ack     = wr_done | (rd_wait & (amm.readdatavalid | tmo_hit));
    assign timeout = rd_wait & ~amm.readdatavalid & tmo_hit;
    assign rdata   = amm.readdata;

    always_ff @(posedge clk) begin
        if (srst) begin
            amm.write     <= 1'b0;
            amm.read      <= 1'b0;
            amm.address   <= '0;
            amm.writedata <= '0;
            rd_wait       <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            // Command registers hold steady until the slave drops waitrequest.
            if (issue) begin
                amm.write     <= issue_wr;
                amm.read      <= ~issue_wr;
                amm.address   <= issue_addr;
                amm.writedata <= issue_data;
            end else begin
                if (wr_done) amm.write <= 1'b0;
                if (rd_acc)  amm.read  <= 1'b0;
            end

            if (rd_acc) begin
                rd_wait  <= 1'b1;
                wait_cnt <= '0;
            end else if (rd_wait) begin
                if (amm.readdatavalid | tmo_hit) rd_wait <= 1'b0;
                else                              wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pattern_cfg_sequencer.sv
// Programs the pattern-match register block atomically: disable, write pattern, optional
// read-back verify, then enable; the matcher is left disabled if verification fails.
module pattern_cfg_sequencer
    import pattern_cfg_pkg::*;
#(
    parameter int REG_WIDTH  = 32,
    parameter int REG_DEPTH  = 4,
    parameter int PAT_WIDTH  = REG_DEPTH - 1,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                                clk_i,
    input  logic                                srst_i,
    input  logic                                start_i,
    input  logic [PAT_WIDTH-1:0][REG_WIDTH-1:0] pattern_i,
    input  logic                                enable_i,
    input  logic                                verify_i,
    avalon_mm_if.master                         amm_master_if,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                error_o,
    output logic [REG_DEPTH-1:0]                err_addr_o
);
    localparam int KW = $clog2(PAT_WIDTH + 1);

    seq_state_t                          state, state_nx;
    logic [KW-1:0]                       k, k_nx;
    logic                                err_nx;
    logic [REG_DEPTH-1:0]                err_addr_nx;
    logic [PAT_WIDTH-1:0][REG_WIDTH-1:0] pat_q;
    logic                                enable_q, verify_q;
    logic                                accept, k_last;

    logic                 issue, issue_wr, issue_ctrl, issue_en;
    logic [REG_DEPTH-1:0] issue_addr;
    logic [REG_WIDTH-1:0] issue_data, ctrl_word;
    logic                 ack, rd_acc, timeout;
    logic [REG_WIDTH-1:0] rdata;

    function automatic logic [REG_DEPTH-1:0] pat_addr(input logic [KW-1:0] idx);
        return REG_DEPTH'(PAT_BASE_ADDR) + REG_DEPTH'(idx);
    endfunction

    assign accept = (state == S_IDLE) && start_i;
    assign k_last = (k == KW'(PAT_WIDTH - 1));
    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_DONE);

    // Each transfer's ack issues the next command in the same cycle.
    always_comb begin
        state_nx    = state;
        k_nx        = k;
        err_nx      = error_o;
        err_addr_nx = err_addr_o;
        issue       = 1'b0;
        issue_wr    = 1'b1;
        issue_ctrl  = 1'b0;
        issue_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nx    = S_DIS_WR;
                    issue       = 1'b1;
                    issue_ctrl  = 1'b1;
                    k_nx        = '0;
                    err_nx      = 1'b0;
                    err_addr_nx = '0;
                end
            end
            S_DIS_WR: begin
                if (ack) begin
                    state_nx = S_PAT_WR;
                    issue    = 1'b1;
                    k_nx     = '0;
                end
            end
            S_PAT_WR: begin
                if (ack) begin
                    issue = 1'b1;
                    if (!k_last) begin
                        k_nx = k + 1'b1;
                    end else if (verify_q) begin
                        state_nx = S_VER_RD;
                        issue_wr = 1'b0;
                        k_nx     = '0;
                    end else begin
                        state_nx   = S_EN_WR;
                        issue_ctrl = 1'b1;
                        issue_en   = 1'b1;
                    end
                end
            end
            S_VER_RD: begin
                if (rd_acc) state_nx = S_VER_WAIT;
            end
            S_VER_WAIT: begin
                if (ack) begin
                    if (timeout || (rdata != pat_q[k])) begin
                        err_nx      = 1'b1;
                        err_addr_nx = pat_addr(k);
                        state_nx    = S_DONE;
                    end else if (!k_last) begin
                        state_nx = S_VER_RD;
                        issue    = 1'b1;
                        issue_wr = 1'b0;
                        k_nx     = k + 1'b1;
                    end else begin
                        state_nx   = S_EN_WR;
                        issue      = 1'b1;
                        issue_ctrl = 1'b1;
                        issue_en   = 1'b1;
                    end
                end
            end
            S_EN_WR: begin
                if (ack) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ctrl_word             = '0;
        ctrl_word[ENABLE_BIT] = issue_en & enable_q;
        issue_addr            = issue_ctrl ? REG_DEPTH'(CTRL_ADDR) : pat_addr(k_nx);
        issue_data            = issue_ctrl ? ctrl_word : pat_q[k_nx];
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state      <= S_IDLE;
            k          <= '0;
            error_o    <= 1'b0;
            err_addr_o <= '0;
            enable_q   <= 1'b0;
            verify_q   <= 1'b0;
        end else begin
            state      <= state_nx;
            k          <= k_nx;
            error_o    <= err_nx;
            err_addr_o <= err_addr_nx;
            if (accept) begin
                enable_q <= enable_i;
                verify_q <= verify_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) pat_q <= pattern_i;
    end

    amm_single_xfer #(
        .ADDR_W     (REG_DEPTH),
        .DATA_W     (REG_WIDTH),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_xfer (
        .clk        (clk_i),
        .srst       (srst_i),
        .issue      (issue),
        .issue_wr   (issue_wr),
        .issue_addr (issue_addr),
        .issue_data (issue_data),
        .ack        (ack),
        .rd_acc     (rd_acc),
        .timeout    (timeout),
        .rdata      (rdata),
        .amm        (amm_master_if)
    );
endmodule
